// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
//
// UART transmit engine. Each valid/ready handshake captures one DATA_BITS-wide
// word and serialises it as: start bit (0), data bits LSB first, an optional
// parity bit, then STOP_BITS stop bits (1). Bit timing comes from an internal
// divider running on uart_clock, so no separate baud clock is needed. A new
// word can be accepted on the final cycle of the last stop bit, which gives
// back-to-back frames with no idle gap between them.
//
// Compile-time option:
//   UART_TX_PARITY_EN  When defined, a PARITY state is compiled in and every
//                      frame carries one parity bit between the data and stop
//                      bits. PARITY_ODD = 1 selects odd parity, 0 even. When
//                      undefined, frames go directly from DATA to STOP and
//                      PARITY_ODD has no effect.
//
// Parameters:
//   DATA_BITS     data bits per frame (5..9)
//   CLKS_PER_BIT  uart_clock cycles per bit period (>= 2)
//   STOP_BITS     stop bits per frame (1 or 2)
//   PARITY_ODD    parity sense, used only with UART_TX_PARITY_EN
//
// Ports:
//   uart_clock  in   clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   data        in   word to send, sampled only on the handshake edge
//   valid       in   data is presented
//   ready       out  engine accepts a word this cycle
//   tx          out  serial line, idles high, registered
//   busy        out  a frame is in progress
//   done        out  one-cycle pulse on the last cycle of the final stop bit
// -----------------------------------------------------------------------------
module uart_tx_frame #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 uart_clock,
  input  logic                 reset_n,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  // Elaboration-time parameter checks.
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be in 5..9");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_frame: CLKS_PER_BIT must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
  end

  localparam int DIV_W = $clog2(CLKS_PER_BIT);
  localparam int CNT_W = $clog2(DATA_BITS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [DIV_W-1:0] DIV_PRELAST = DIV_W'(CLKS_PER_BIT - 2);
  localparam logic [CNT_W-1:0] BIT_LAST    = CNT_W'(DATA_BITS - 1);
  // Index of the final stop bit in the one-bit stop counter.
  localparam logic             STOP_LAST   = (STOP_BITS == 2);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic PAR_SENSE = (PARITY_ODD != 0);
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;
`endif

  state_t               state;
  logic [DIV_W-1:0]     div_cnt;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shift;
`ifdef UART_TX_PARITY_EN
  logic                 parity_bit;
`endif

  logic accept;
  logic bit_end;
  logic stop_prelast;

  // ready is only ever high in IDLE or on the final stop cycle, so a
  // handshake can only land at those two points.
  assign accept  = valid && ready;
  assign bit_end = (div_cnt == DIV_LAST);

  // True one cycle before the last cycle of the final stop bit: ready and
  // done are registered, so they are raised on this edge to be high during
  // that last cycle.
  assign stop_prelast = (state == STOP) && (stop_cnt == STOP_LAST) &&
                        (div_cnt == DIV_PRELAST);

  always_ff @(posedge uart_clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      shift      <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
      tx         <= 1'b1;
      ready      <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;

      if (accept) begin
        // Handshake: from IDLE, or back-to-back on the final stop cycle.
        shift      <= data;
`ifdef UART_TX_PARITY_EN
        parity_bit <= (^data) ^ PAR_SENSE;
`endif
        div_cnt    <= '0;
        state      <= START;
        tx         <= 1'b0;
        busy       <= 1'b1;
        ready      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            tx    <= 1'b1;
            busy  <= 1'b0;
            ready <= 1'b1;
          end

          START: begin
            if (bit_end) begin
              div_cnt <= '0;
              bit_cnt <= '0;
              state   <= DATA;
              tx      <= shift[0];
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end

          DATA: begin
            if (bit_end) begin
              div_cnt <= '0;
              shift   <= shift >> 1;
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                state    <= PARITY;
                tx       <= parity_bit;
`else
                state    <= STOP;
                stop_cnt <= 1'b0;
                tx       <= 1'b1;
`endif
              end else begin
                // shift[1] becomes shift[0] on this same edge.
                tx <= shift[1];
              end
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end

`ifdef UART_TX_PARITY_EN
          PARITY: begin
            if (bit_end) begin
              div_cnt  <= '0;
              state    <= STOP;
              stop_cnt <= 1'b0;
              tx       <= 1'b1;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
`endif

          STOP: begin
            tx <= 1'b1;
            if (bit_end) begin
              div_cnt <= '0;
              if (stop_cnt == STOP_LAST) begin
                // No handshake on the final cycle: go idle. ready is
                // already high from the previous edge.
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                stop_cnt <= stop_cnt + 1'b1;
              end
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
            if (stop_prelast) begin
              ready <= 1'b1;
              done  <= 1'b1;
            end
          end

          default: begin
            state <= IDLE;
            tx    <= 1'b1;
            busy  <= 1'b0;
            ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_frame
//
// Bench for uart_tx_frame with CLKS_PER_BIT = 4 and three instances:
//   u_a : DATA_BITS 8, STOP_BITS 1, PARITY_ODD 0
//   u_b : DATA_BITS 7, STOP_BITS 2, PARITY_ODD 0
//   u_c : DATA_BITS 8, STOP_BITS 1, PARITY_ODD 1
// Expected line patterns are written out by hand, one character per bit
// period, and differ between builds with and without UART_TX_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_uart_tx_frame;

  localparam int CPB = 4;

  logic uart_clock = 1'b0;
  always #5 uart_clock = ~uart_clock;

  logic       reset_n;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic [7:0] data_c;
  logic [2:0] valid_r;
  logic       tx_a, tx_b, tx_c;
  logic       ready_a, ready_b, ready_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;
  logic [2:0] tx_w, ready_w, busy_w, done_w;

  assign tx_w    = {tx_c, tx_b, tx_a};
  assign ready_w = {ready_c, ready_b, ready_a};
  assign busy_w  = {busy_c, busy_b, busy_a};
  assign done_w  = {done_c, done_b, done_a};

  uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)) u_a (
    .uart_clock(uart_clock), .reset_n(reset_n), .data(data_a), .valid(valid_r[0]),
    .ready(ready_a), .tx(tx_a), .busy(busy_a), .done(done_a));

  uart_tx_frame #(.DATA_BITS(7), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(0)) u_b (
    .uart_clock(uart_clock), .reset_n(reset_n), .data(data_b), .valid(valid_r[1]),
    .ready(ready_b), .tx(tx_b), .busy(busy_b), .done(done_b));

  uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(1)) u_c (
    .uart_clock(uart_clock), .reset_n(reset_n), .data(data_c), .valid(valid_r[2]),
    .ready(ready_c), .tx(tx_c), .busy(busy_c), .done(done_c));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         inst;
    logic [7:0] word;
    string      pat;
    bit         disturb;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int cyc, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic set_data(input int inst, input logic [7:0] w);
    case (inst)
      0:       data_a = w;
      1:       data_b = w[6:0];
      default: data_c = w;
    endcase
  endtask

  // Present a word at a falling edge; handshake on the next rising edge.
  task automatic start_frame(input int inst, input logic [7:0] w);
    @(negedge uart_clock);
    chk("ready_before_handshake", 0, 32'(ready_w[inst]), 32'd1);
    set_data(inst, w);
    valid_r[inst] = 1'b1;
    @(posedge uart_clock);
    #1 valid_r[inst] = 1'b0;
  endtask

  // Check every cycle of one frame whose handshake edge has just passed.
  // With disturb set, data and valid are wiggled mid-frame.
  task automatic check_frame(input int inst, input string pat, input bit disturb);
    int f;
    logic exp_tx;
    f = pat.len() * CPB;
    for (int j = 1; j <= f; j++) begin
      @(negedge uart_clock);
      exp_tx = (pat[(j - 1) / CPB] == 8'h31);
      chk("tx",    j, 32'(tx_w[inst]),    32'(exp_tx));
      chk("busy",  j, 32'(busy_w[inst]),  32'd1);
      chk("ready", j, 32'(ready_w[inst]), 32'(j == f));
      chk("done",  j, 32'(done_w[inst]),  32'(j == f));
      if (disturb) begin
        if (j >= CPB + 1 && j < f - 2 * CPB) begin
          set_data(inst, 8'(j * 37));
          valid_r[inst] = (j % 3) != 0;
        end else begin
          valid_r[inst] = 1'b0;
        end
      end
    end
  endtask

  task automatic check_idle(input int inst);
    @(negedge uart_clock);
    chk("idle_tx",    -1, 32'(tx_w[inst]),    32'd1);
    chk("idle_ready", -1, 32'(ready_w[inst]), 32'd1);
    chk("idle_busy",  -1, 32'(busy_w[inst]),  32'd0);
    chk("idle_done",  -1, 32'(done_w[inst]),  32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
`ifdef UART_TX_PARITY_EN
    vecs[0] = '{0, 8'hA5, "01010010101", 1'b0};
    vecs[1] = '{1, 8'h41, "01000001011", 1'b0};
    vecs[2] = '{2, 8'hA5, "01010010111", 1'b0};
    vecs[3] = '{0, 8'h3C, "00011110001", 1'b1};
    vecs[4] = '{1, 8'h01, "01000000111", 1'b0};
    vecs[5] = '{2, 8'hFF, "01111111111", 1'b1};
`else
    vecs[0] = '{0, 8'hA5, "0101001011", 1'b0};
    vecs[1] = '{1, 8'h41, "0100000111", 1'b0};
    vecs[2] = '{2, 8'hA5, "0101001011", 1'b0};
    vecs[3] = '{0, 8'h3C, "0001111001", 1'b1};
    vecs[4] = '{1, 8'h01, "0100000011", 1'b0};
    vecs[5] = '{2, 8'hFF, "0111111111", 1'b1};
`endif

    reset_n = 1'b0;
    valid_r = 3'b000;
    data_a  = '0;
    data_b  = '0;
    data_c  = '0;

    repeat (3) @(negedge uart_clock);
    for (int i = 0; i < 3; i++) begin
      chk("reset_tx",    i, 32'(tx_w[i]),    32'd1);
      chk("reset_ready", i, 32'(ready_w[i]), 32'd1);
      chk("reset_busy",  i, 32'(busy_w[i]),  32'd0);
      chk("reset_done",  i, 32'(done_w[i]),  32'd0);
    end
    reset_n = 1'b1;
    check_idle(0);

    // Table-driven frames.
    for (int v = 0; v < 6; v++) begin
      start_frame(vecs[v].inst, vecs[v].word);
      check_frame(vecs[v].inst, vecs[v].pat, vecs[v].disturb);
      check_idle(vecs[v].inst);
    end

    // Back-to-back: valid held high, 0x00 then 0xFF, no idle gap.
    @(negedge uart_clock);
    data_a     = 8'h00;
    valid_r[0] = 1'b1;
    @(posedge uart_clock);
    #1 data_a = 8'hFF;
`ifdef UART_TX_PARITY_EN
    check_frame(0, "00000000001", 1'b0);
`else
    check_frame(0, "0000000001", 1'b0);
`endif
    @(posedge uart_clock);
    #1 valid_r[0] = 1'b0;
`ifdef UART_TX_PARITY_EN
    check_frame(0, "01111111101", 1'b0);
`else
    check_frame(0, "0111111111", 1'b0);
`endif
    check_idle(0);

    // Reset pulsed during DATA: line returns high at once, frame abandoned.
    start_frame(0, 8'hA5);
    repeat (14) @(negedge uart_clock);
    chk("pre_reset_busy", 14, 32'(busy_w[0]), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_tx",    0, 32'(tx_a),    32'd1);
    chk("async_reset_ready", 0, 32'(ready_a), 32'd1);
    chk("async_reset_busy",  0, 32'(busy_a),  32'd0);
    chk("async_reset_done",  0, 32'(done_a),  32'd0);
    repeat (2) @(negedge uart_clock);
    reset_n = 1'b1;
    for (int j = 1; j <= 50; j++) begin
      @(negedge uart_clock);
      chk("post_reset_done", j, 32'(done_a), 32'd0);
      chk("post_reset_tx",   j, 32'(tx_a),   32'd1);
    end
    start_frame(0, 8'hA5);
`ifdef UART_TX_PARITY_EN
    check_frame(0, "01010010101", 1'b0);
`else
    check_frame(0, "0101001011", 1'b0);
`endif
    check_idle(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmit engine that serialises one DATA_BITS-wide word per valid/ready handshake into a start bit, LSB-first data bits, optional parity bit, and 1 or 2 stop bits. It runs from the system clock and uses an internal bit-period divider, so no separate baud clock is needed. It replaces the fixed 11-bit packet shifter in the UART datapath and feeds the tx pin directly. Words can be accepted back-to-back with no idle gap between frames.

## Interface
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- CLKS_PER_BIT, 16: uart_clock cycles per bit period; legal minimum 2.
- STOP_BITS, 1: stop bits per frame; legal values 1 or 2.
- PARITY_ODD, 0: 1 selects odd parity, 0 selects even. Used only when UART_TX_PARITY_EN is defined.

- uart_clock  in  1  the only clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- data  in  DATA_BITS  word to send; sampled only on the handshake edge.
- valid  in  1  data is presented.
- ready  out  1  engine can accept a word this cycle.
- tx  out  1  serial line; idles high.
- busy  out  1  a frame is in progress (any state other than IDLE).
- done  out  1  one-cycle pulse on the last cycle of the final stop bit.

## Operation
- FSM states: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- Handshake occurs when valid && ready on a rising edge. On that edge the engine captures data into a shift register, clears the divider, and moves to START.
- ready = 1 in IDLE and during the final cycle of the last stop bit. It is 0 at all other times.
- START: tx = 0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: tx = shift[0] each bit period. Shift right at the end of each period. After DATA_BITS periods, go to PARITY, or to STOP if the macro is absent.
- PARITY: tx = ^captured_word ^ PARITY_ODD for one bit period.
- STOP: tx = 1 for STOP_BITS × CLKS_PER_BIT cycles. On the last cycle, assert done.
  - If a handshake occurs on that same edge, go to START (back-to-back frames).
  - Otherwise go to IDLE.
- Divider: counter width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- Bit counter: width $clog2(DATA_BITS+1). It is cleared on entry to DATA.
- tx is registered; it has no combinational path from any input.
- Changes on data or valid while busy have no effect on the frame in progress.
- Reset values: tx = 1, ready = 1, busy = 0, done = 0, state = IDLE, counters = 0, shift register = 0.
- Reset asserted mid-frame: tx returns high immediately (asynchronously) and the frame is abandoned. No done pulse is issued.

## Timing
- Handshake on edge N: tx = 0 from edge N+1. The start bit covers edges N+1..N+CLKS_PER_BIT.
- Frame length F = (1 + DATA_BITS + P + STOP_BITS) × CLKS_PER_BIT cycles, where P = 1 if the macro is defined, else 0.
- done and ready are high together during cycle N+F. They both fall at edge N+F+1 unless no new handshake occurs, in which case ready stays high.
- Back-to-back: a handshake at edge N+F puts the next start bit at edge N+F+1. The stop bit is never shortened.
- busy is high from edge N+1 through cycle N+F.

## Configuration
- UART_TX_PARITY_EN defined:
  - PARITY state is compiled in.
  - Each frame carries one parity bit between the data bits and the stop bits.
  - PARITY_ODD selects the parity sense.
- UART_TX_PARITY_EN undefined:
  - No PARITY state, no parity logic, and PARITY_ODD is ignored.
  - Frames go directly from DATA to STOP.

## Test plan
- Defaults with CLKS_PER_BIT = 4, no macro, data = 0xA5:
  - tx bits 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
  - Frame is 40 cycles; done pulses exactly once on cycle 40 after the handshake.
- Macro defined, data = 0xA5 (four ones):
  - PARITY_ODD = 0 gives parity bit 0; PARITY_ODD = 1 gives parity bit 1.
  - Frame is 44 cycles.
- Back-to-back with valid held high and words 0x00 then 0xFF:
  - Stop bit of frame 1 is exactly 4 cycles high.
  - Start bit of frame 2 follows immediately; no extra idle cycle.
- DATA_BITS = 7, STOP_BITS = 2, data = 0x41:
  - Bits 0,1,0,0,0,0,0,1,1,1.
  - Stop bits are 8 cycles high total; frame is 40 cycles.
- reset_n pulsed low during the DATA state:
  - tx = 1 asynchronously, with ready = 1, busy = 0, done = 0.
  - No done pulse follows; the next handshake produces a clean full frame.
- Change data and pulse valid while busy: the transmitted frame is unchanged and ready stays 0.
